ram_param: RTL and testbench



---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_clear_seq.sv | 63 ++++++
 rtl/ram_param.sv | 104 ++++++++++
 tb/tb_ram_param.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the parametrised RAM.
//   state_t           clear-engine state (IDLE, CLEAR)
//   RD_FIRST/WR_FIRST read-during-write mode values for WRITE_THROUGH
package ram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: clear engine for ram_param. Sweeps clr_addr from 0 to
// DEPTH-1, one word per cycle, after reset or an accepted clear_req.
//   state | meaning
//   IDLE  | memory usable, waiting for clear_req
//   CLEAR | sweeping, one word zeroed per edge
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clear_req   request a sweep (ignored while already sweeping)
//   busy        sweep in progress
//   clr_we      write a zero word at clr_addr this edge
//   clr_addr    word currently being cleared
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                // Pointer wraps to 0 on the last word; unused in IDLE.
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = clr_addr_q;

endmodule

// File: rtl/ram_param.sv
// ram_param: parametrised single-port synchronous RAM with a sequential
// clear engine and selectable read-during-write behaviour.
// Ports:
//   clk, reset    clock and synchronous active-high reset (starts a sweep)
//   address       word address
//   data_in       write data
//   write_enable  write data_in to mem[address]
//   read_enable   read mem[address] into data_out
//   clear_req     zero the whole array (wins over a same-edge access)
//   data_out      registered read data
//   read_valid    high the cycle after an accepted read
//   busy          sweep in progress, accesses ignored
module ram_param
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int WRITE_THROUGH = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic                  clear_req,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  read_valid,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  read_valid_q;

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  user_wr, user_rd;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    ram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_seq (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // A user access needs an idle engine and no competing clear request.
    assign user_wr = !busy && !clear_req && write_enable;
    assign user_rd = !busy && !clear_req && read_enable;

    // Single write port shared between the sweep and the user.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = address;
        wr_data = data_in;
        if (!reset) begin
            if (clr_we) begin
                wr_en   = 1'b1;
                wr_addr = clr_addr;
                wr_data = '0;
            end else if (user_wr) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        if (user_rd) begin
            if (WRITE_THROUGH == WR_FIRST && write_enable) begin
                data_out_d = data_in;
            end else begin
                data_out_d = mem_q[address];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q   <= '0;
            read_valid_q <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            read_valid_q <= user_rd;
        end
    end

    assign data_out   = data_out_q;
    assign read_valid = read_valid_q;

endmodule

// File: tb/tb_ram_param.sv
module tb_ram_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] address;
    logic [7:0] data_in;
    logic       write_enable, read_enable, clear_req;
    logic [7:0] dout0, dout1;
    logic       rv0, rv1, busy0, busy1;

    int tests = 0;
    int fails = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WRITE_THROUGH(0)) dut_rf (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .write_enable(write_enable), .read_enable(read_enable), .clear_req(clear_req),
        .data_out(dout0), .read_valid(rv0), .busy(busy0)
    );

    ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WRITE_THROUGH(1)) dut_wf (
        .clk(clk), .reset(reset), .address(address), .data_in(data_in),
        .write_enable(write_enable), .read_enable(read_enable), .clear_req(clear_req),
        .data_out(dout1), .read_valid(rv1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear_req    = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic [7:0] e0, e1;
        idle_inputs();
        address = '0;
        data_in = '0;
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1 || rv0 !== 1'b0 || rv1 !== 1'b0 ||
            dout0 !== 8'h00 || dout1 !== 8'h00) begin
            fails++;
            $display("FAIL reset_state: busy=%b/%b rv=%b/%b dout=%h/%h, required busy=1 rv=0 dout=00",
                     busy0, busy1, rv0, rv1, dout0, dout1);
        end
        reset = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (n != 16 || busy1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_sweep_len: busy cycles=%0d busy_wf=%b, required 16 and 0", n, busy1);
        end
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            read_enable = 1'b1;
            q0.push_back(8'h00);
            q1.push_back(8'h00);
            tick();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            tests++;
            if (rv0 !== 1'b1 || rv1 !== 1'b1 || dout0 !== e0 || dout1 !== e1) begin
                fails++;
                $display("FAIL reset_read_zero[%0d]: rv=%b/%b dout=%h/%h, required rv=1 dout=%h/%h",
                         a, rv0, rv1, dout0, dout1, e0, e1);
            end
        end
        read_enable = 1'b0;
        tick();
        tests++;
        if (rv0 !== 1'b0 || rv1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_rv_drop: rv=%b/%b, required 0", rv0, rv1);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] addrs [3];
        logic [7:0] e0, e1;
        addrs[0] = 4'd3; addrs[1] = 4'd15; addrs[2] = 4'd4;
        idle_inputs();
        write_enable = 1'b1;
        address = 4'd3;  data_in = 8'hA5; tick();
        tests++;
        if (rv0 !== 1'b0 || dout0 !== 8'h00) begin
            fails++;
            $display("FAIL write_no_read: rv=%b dout=%h, required rv=0 dout=00", rv0, dout0);
        end
        address = 4'd15; data_in = 8'h3C; tick();
        write_enable = 1'b0;
        read_enable = 1'b1;
        q0.push_back(8'hA5); q1.push_back(8'hA5);
        q0.push_back(8'h3C); q1.push_back(8'h3C);
        q0.push_back(8'h00); q1.push_back(8'h00);
        for (int i = 0; i < 3; i++) begin
            address = addrs[i];
            tick();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            tests++;
            if (rv0 !== 1'b1 || rv1 !== 1'b1 || dout0 !== e0 || dout1 !== e1) begin
                fails++;
                $display("FAIL b2b_read[%0d]: rv=%b/%b dout=%h/%h, required rv=1 dout=%h/%h",
                         i, rv0, rv1, dout0, dout1, e0, e1);
            end
        end
        read_enable = 1'b0;
        tick();
    endtask

    task automatic test_read_during_write();
        logic [7:0] e0, e1;
        idle_inputs();
        write_enable = 1'b1; address = 4'd5; data_in = 8'h11; tick();
        read_enable = 1'b1; data_in = 8'h77;
        q0.push_back(8'h11);
        q1.push_back(8'h77);
        tick();
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        tests++;
        if (rv0 !== 1'b1 || rv1 !== 1'b1 || dout0 !== e0 || dout1 !== e1) begin
            fails++;
            $display("FAIL rdw_mode: rv=%b/%b dout rf=%h wf=%h, required rf=%h wf=%h",
                     rv0, rv1, dout0, dout1, e0, e1);
        end
        write_enable = 1'b0;
        q0.push_back(8'h77);
        q1.push_back(8'h77);
        tick();
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        tests++;
        if (dout0 !== e0 || dout1 !== e1) begin
            fails++;
            $display("FAIL rdw_followup: dout=%h/%h, required %h/%h", dout0, dout1, e0, e1);
        end
        read_enable = 1'b0;
        tick();
    endtask

    task automatic test_clear_req();
        int n;
        idle_inputs();
        write_enable = 1'b1; address = 4'd2; data_in = 8'h12; tick();
        // Clear request with a simultaneous write + read: access dropped.
        clear_req = 1'b1; read_enable = 1'b1; data_in = 8'hFF;
        tick();
        idle_inputs();
        tests++;
        if (busy0 !== 1'b1 || rv0 !== 1'b0 || rv1 !== 1'b0 || dout0 !== 8'h77 || dout1 !== 8'h77) begin
            fails++;
            $display("FAIL clear_accept: busy=%b rv=%b/%b dout=%h/%h, required busy=1 rv=0 dout=77",
                     busy0, rv0, rv1, dout0, dout1);
        end
        n = 1;
        while (busy0 === 1'b1 && n < 40) begin
            clear_req = (n == 5);
            tick();
            n++;
        end
        clear_req = 1'b0;
        tests++;
        if (n != 17) begin
            fails++;
            $display("FAIL clear_busy_len: busy cycles=%0d, required 16", n - 1);
        end
        address = 4'd2; read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        tests++;
        if (rv0 !== 1'b1 || dout0 !== 8'h00 || dout1 !== 8'h00) begin
            fails++;
            $display("FAIL clear_mem2: rv=%b dout=%h/%h, required rv=1 dout=00", rv0, dout0, dout1);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        int bad;
        idle_inputs();
        write_enable = 1'b1;
        address = 4'd9;  data_in = 8'h99; tick();
        address = 4'd12; data_in = 8'h42; tick();
        address = 4'd1;  data_in = 8'hC3; tick();
        write_enable = 1'b0;
        clear_req = 1'b1; tick();
        clear_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        tests++;
        if (busy0 !== 1'b1 || dout0 !== 8'h00 || rv0 !== 1'b0) begin
            fails++;
            $display("FAIL midsweep_reset_state: busy=%b dout=%h rv=%b, required 1/00/0", busy0, dout0, rv0);
        end
        n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (n != 16) begin
            fails++;
            $display("FAIL midsweep_busy_len: busy cycles=%0d, required 16", n);
        end
        bad = 0;
        read_enable = 1'b1;
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            q0.push_back(8'h00);
            tick();
            if (rv0 !== 1'b1 || dout0 !== q0.pop_front() || dout1 !== 8'h00) bad++;
        end
        read_enable = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midsweep_all_zero: bad words=%0d, required 0", bad);
        end
    endtask

    task automatic test_busy_access();
        int n;
        int bad;
        idle_inputs();
        write_enable = 1'b1; address = 4'd6; data_in = 8'h5A; tick();
        write_enable = 1'b0; read_enable = 1'b1; tick();
        read_enable = 1'b0;
        clear_req = 1'b1; tick();
        clear_req = 1'b0;
        n = 0;
        bad = 0;
        while (busy0 === 1'b1 && n < 40) begin
            write_enable = 1'b1; read_enable = 1'b1; address = 4'd6; data_in = 8'h55;
            tick();
            if (rv0 !== 1'b0 || rv1 !== 1'b0 || dout0 !== 8'h5A || dout1 !== 8'h5A) bad++;
            n++;
        end
        idle_inputs();
        tests++;
        if (bad != 0 || n != 16) begin
            fails++;
            $display("FAIL busy_ignored: bad cycles=%0d busy cycles=%0d, required 0 and 16", bad, n);
        end
        address = 4'd6; read_enable = 1'b1;
        q0.push_back(8'h00); q1.push_back(8'h00);
        tick();
        read_enable = 1'b0;
        tests++;
        if (rv0 !== 1'b1 || dout0 !== q0.pop_front() || dout1 !== q1.pop_front()) begin
            fails++;
            $display("FAIL busy_write_dropped: rv=%b dout=%h/%h, required rv=1 dout=00", rv0, dout0, dout1);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_read_during_write();
        test_clear_req();
        test_reset_mid_sweep();
        test_busy_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
